// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART transmitter
// Contents: parity mode encodings, transmit FSM state type, default baud divisor.
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int BAUD_DIV_DEFAULT = 868;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous-read byte FIFO feeding the UART transmitter
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write strobe and byte (ignored when full)
//   pop, pop_data     read strobe; pop_data is registered and valid the cycle after pop
//   empty, full       occupancy flags derived from level
//   level             current occupancy, 0..FIFO_DEPTH
//   ready             registered "can accept": !full for the occupancy after this edge
module uart_tx_fifo #(
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    output logic          ready
);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [LW-1:0] level_next;

    assign empty   = (level == '0);
    assign full    = (level == LW'(FIFO_DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Simultaneous push and pop leaves the level unchanged.
    assign level_next = level + LW'(do_push) - LW'(do_pop);

    // Pointers are AW bits wide so they wrap modulo FIFO_DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pop_data <= '0;
            ready    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                pop_data <= mem[rd_ptr];
            end
            level <= level_next;
            ready <= (level_next != LW'(FIFO_DEPTH));
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_encoder.sv
// rtl/uart_encoder.sv - UART transmitter with byte FIFO, LSB-first framing
// Ports:
//   wb_clk_i      system clock
//   wb_rst_i      asynchronous active-high reset
//   tx_data_i     byte to transmit
//   tx_valid_i    tx_data_i valid; transfer on valid & ready at a rising edge
//   tx_ready_o    FIFO can accept (registered)
//   uart_tx_o     serial line, idle high (registered)
//   busy_o        frame on the line or FIFO non-empty (registered)
//   fifo_level_o  current FIFO occupancy
module uart_encoder import uart_pkg::*; #(
    parameter  int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter  int FIFO_DEPTH = 16,
    parameter  int PARITY     = PAR_NONE,
    parameter  int STOP_BITS  = 1,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [7:0]    tx_data_i,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    output logic          uart_tx_o,
    output logic          busy_o,
    output logic [LW-1:0] fifo_level_o
);

    tx_state_t     state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic          stop_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic          baud_end;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_ready;
    logic [LW-1:0] fifo_level;

    assign fifo_push    = tx_valid_i & tx_ready_o & ~fifo_full;
    // IDLE pops as soon as it sees data; the byte is read out one cycle later.
    assign fifo_pop     = (state == ST_IDLE) & ~fifo_empty;
    assign tx_ready_o   = fifo_ready;
    assign fifo_level_o = fifo_level;
    assign baud_end     = (baud_cnt == 16'(BAUD_DIV - 1));

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (fifo_push),
        .push_data (tx_data_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level),
        .ready     (fifo_ready)
    );

    // The line register follows the state one clock behind, so every bit is
    // still exactly BAUD_DIV clocks wide and the start bit leaves the pin one
    // clock after the pop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shift     <= '0;
            par_bit   <= 1'b0;
            uart_tx_o <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            busy_o <= (state != ST_IDLE) || (fifo_level != '0);
            case (state)
                ST_IDLE: begin
                    uart_tx_o <= 1'b1;
                    baud_cnt  <= '0;
                    if (!fifo_empty) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    uart_tx_o <= 1'b0;
                    if (baud_end) begin
                        // Popped byte has been stable in fifo_data since the cycle after the pop.
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        shift    <= fifo_data;
                        par_bit  <= (^fifo_data) ^ (PARITY == PAR_ODD);
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    uart_tx_o <= shift[0];
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            stop_cnt <= 1'b0;
                            state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_PARITY: begin
                    uart_tx_o <= par_bit;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    uart_tx_o <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    uart_tx_o <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_encoder.sv
// tb/tb_uart_encoder.sv - directed self-checking bench for uart_encoder
module tb_uart_encoder;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       valid_a = 1'b0, valid_e = 1'b0, valid_o = 1'b0;
    logic       ready_a, ready_e, ready_o;
    logic       tx_a, tx_e, tx_o;
    logic       busy_a, busy_e, busy_o;
    logic [4:0] level_a, level_e, level_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // A: no parity, 1 stop.  E: even parity, 2 stops.  O: odd parity, 1 stop.
    uart_encoder #(.BAUD_DIV(4), .FIFO_DEPTH(16), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(valid_a),
        .tx_ready_o(ready_a), .uart_tx_o(tx_a), .busy_o(busy_a), .fifo_level_o(level_a));
    uart_encoder #(.BAUD_DIV(4), .FIFO_DEPTH(16), .PARITY(PAR_EVEN), .STOP_BITS(2)) dut_e (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(valid_e),
        .tx_ready_o(ready_e), .uart_tx_o(tx_e), .busy_o(busy_e), .fifo_level_o(level_e));
    uart_encoder #(.BAUD_DIV(4), .FIFO_DEPTH(16), .PARITY(PAR_ODD), .STOP_BITS(1)) dut_o (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(valid_o),
        .tx_ready_o(ready_o), .uart_tx_o(tx_o), .busy_o(busy_o), .fifo_level_o(level_o));

    // Bench UART decoder on dut_a: samples mid-bit, stores {stop, data}.
    logic [8:0] rx_q [$];
    logic       dec_en = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_start;

    always begin
        @(negedge tx_a);
        if (!rst) begin
            repeat (2) @(posedge clk);
            #1 rx_start = tx_a;
            if (!rx_start) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #1 rx_byte[i] = tx_a;
                end
                repeat (4) @(posedge clk);
                #1;
                if (dec_en) rx_q.push_back({tx_a, rx_byte});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        total++; if (tx_a !== 1'b1)       begin bad++; $display("FAIL rst_tx got=%b exp=1", tx_a); end
        total++; if (ready_a !== 1'b0)    begin bad++; $display("FAIL rst_ready got=%b exp=0", ready_a); end
        total++; if (busy_a !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
        total++; if (level_a !== 5'd0)    begin bad++; $display("FAIL rst_level got=%0d exp=0", level_a); end
        total++; if (tx_e !== 1'b1)       begin bad++; $display("FAIL rst_tx_e got=%b exp=1", tx_e); end
        rst = 1'b0;
        total++; if (ready_a !== 1'b0)    begin bad++; $display("FAIL rel_ready_pre got=%b exp=0", ready_a); end
        tick();
        total++; if (ready_a !== 1'b1)    begin bad++; $display("FAIL rel_ready got=%b exp=1", ready_a); end
        total++; if (ready_o !== 1'b1)    begin bad++; $display("FAIL rel_ready_o got=%b exp=1", ready_o); end
        total++; if (level_a !== 5'd0)    begin bad++; $display("FAIL rel_level got=%0d exp=0", level_a); end
        total++; if (busy_a !== 1'b0)     begin bad++; $display("FAIL rel_busy got=%b exp=0", busy_a); end
    endtask

    // 0x55: line 0,1,0,1,0,1,0,1,0,1 each for 4 clocks starting 2 clocks after the push.
    task automatic test_single_frame;
        logic [9:0] fr;
        fr = 10'b1_01010101_0;
        tx_data = 8'h55; valid_a = 1'b1;
        tick();                                  // edge N: push
        valid_a = 1'b0;
        total++; if (level_a !== 5'd1)   begin bad++; $display("FAIL sf_level_push got=%0d exp=1", level_a); end
        total++; if (busy_a !== 1'b0)    begin bad++; $display("FAIL sf_busy_push got=%b exp=0", busy_a); end
        tick();                                  // edge N+1: pop
        total++; if (level_a !== 5'd0)   begin bad++; $display("FAIL sf_level_pop got=%0d exp=0", level_a); end
        total++; if (tx_a !== 1'b1)      begin bad++; $display("FAIL sf_tx_pop got=%b exp=1", tx_a); end
        total++; if (busy_a !== 1'b1)    begin bad++; $display("FAIL sf_busy_pop got=%b exp=1", busy_a); end
        for (int j = 0; j < 40; j++) begin
            tick();                              // edge N+2+j
            total++; if (tx_a !== fr[j/4]) begin bad++; $display("FAIL sf_line j=%0d got=%b exp=%b", j, tx_a, fr[j/4]); end
            total++; if (busy_a !== 1'b1)  begin bad++; $display("FAIL sf_busy j=%0d got=%b exp=1", j, busy_a); end
        end
        tick();                                  // edge N+42: stop bit over
        total++; if (tx_a !== 1'b1)      begin bad++; $display("FAIL sf_tx_idle got=%b exp=1", tx_a); end
        total++; if (busy_a !== 1'b0)    begin bad++; $display("FAIL sf_busy_end got=%b exp=0", busy_a); end
    endtask

    // 0xA3 LSB first: 1,1,0,0,0,1,0,1 (four ones). Even parity bit 0, odd parity bit 1.
    task automatic test_parity;
        logic [11:0] fe;
        logic [10:0] fo;
        logic        exp_e, exp_o;
        fe = 12'b1_1_0_10100011_0;               // start, data, parity 0, two stops
        fo = 11'b1_1_10100011_0;                 // start, data, parity 1, one stop
        tx_data = 8'hA3; valid_e = 1'b1; valid_o = 1'b1;
        tick();
        valid_e = 1'b0; valid_o = 1'b0;
        tick();
        for (int j = 0; j <= 48; j++) begin
            tick();
            exp_e = (j < 48) ? fe[j/4] : 1'b1;
            exp_o = (j < 44) ? fo[j/4] : 1'b1;
            total++; if (tx_e !== exp_e)          begin bad++; $display("FAIL par_even j=%0d got=%b exp=%b", j, tx_e, exp_e); end
            total++; if (tx_o !== exp_o)          begin bad++; $display("FAIL par_odd j=%0d got=%b exp=%b", j, tx_o, exp_o); end
            total++; if (busy_e !== (j < 48))     begin bad++; $display("FAIL par_busy_e j=%0d got=%b exp=%b", j, busy_e, (j < 48)); end
            total++; if (busy_o !== (j < 44))     begin bad++; $display("FAIL par_busy_o j=%0d got=%b exp=%b", j, busy_o, (j < 44)); end
        end
    endtask

    // Filler 0x7E is on the line while 0x11,0x22,0x33 are pushed; each frame is
    // 40 clocks plus exactly one idle clock.
    task automatic test_back_to_back;
        logic [7:0] seq [4];
        logic [7:0] cur;
        logic       exp;
        int         f, r;
        seq = '{8'h7E, 8'h11, 8'h22, 8'h33};
        tx_data = 8'h7E; valid_a = 1'b1;
        tick();                                  // edge N
        valid_a = 1'b0;
        tick();                                  // edge N+1: filler popped
        tx_data = 8'h11; valid_a = 1'b1;
        for (int j = 0; j < 164; j++) begin
            tick();                              // edge N+2+j
            f = j / 41;
            r = j % 41;
            if (r == 40)      exp = 1'b1;
            else if (r < 4)   exp = 1'b0;
            else if (r >= 36) exp = 1'b1;
            else begin cur = seq[f]; exp = cur[r/4-1]; end
            total++; if (tx_a !== exp)       begin bad++; $display("FAIL b2b_line j=%0d got=%b exp=%b", j, tx_a, exp); end
            total++; if (busy_a !== (j < 163)) begin bad++; $display("FAIL b2b_busy j=%0d got=%b exp=%b", j, busy_a, (j < 163)); end
            if (j <= 2) begin
                total++; if (level_a !== 5'(j + 1)) begin bad++; $display("FAIL b2b_fill j=%0d got=%0d exp=%0d", j, level_a, j + 1); end
            end
            if (r == 40 && f < 3) begin
                total++; if (level_a !== 5'(2 - f)) begin bad++; $display("FAIL b2b_drain j=%0d got=%0d exp=%0d", j, level_a, 2 - f); end
            end
            if (j == 0) tx_data = 8'h22;
            if (j == 1) tx_data = 8'h33;
            if (j == 2) valid_a = 1'b0;
        end
    endtask

    task automatic test_fifo_full;
        int guard;
        rx_q.delete();
        dec_en = 1'b1;
        for (int k = 0; k < 17; k++) begin
            total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL full_ready_k k=%0d got=%b exp=1", k, ready_a); end
            tx_data = 8'(k); valid_a = 1'b1;
            tick();                              // edge N+k
        end
        valid_a = 1'b0;
        total++; if (level_a !== 5'd16)  begin bad++; $display("FAIL full_level got=%0d exp=16", level_a); end
        total++; if (ready_a !== 1'b0)   begin bad++; $display("FAIL full_ready got=%b exp=0", ready_a); end
        repeat (25) tick();                      // edge N+41: first frame's stop ends
        total++; if (ready_a !== 1'b0)   begin bad++; $display("FAIL full_ready_hold got=%b exp=0", ready_a); end
        tick();                                  // edge N+42: second pop
        total++; if (level_a !== 5'd15)  begin bad++; $display("FAIL full_level_pop got=%0d exp=15", level_a); end
        total++; if (ready_a !== 1'b1)   begin bad++; $display("FAIL full_ready_back got=%b exp=1", ready_a); end
        guard = 0;
        while (rx_q.size() < 17 && guard < 900) begin tick(); guard++; end
        total++; if (rx_q.size() != 17)  begin bad++; $display("FAIL full_count got=%0d exp=17", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 17; i++) begin
            total++; if (rx_q[i] !== {1'b1, 8'(i)}) begin bad++; $display("FAIL full_byte i=%0d got=%h exp=%h", i, rx_q[i], {1'b1, 8'(i)}); end
        end
        dec_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        int guard;
        dec_en = 1'b0;
        // 0xFF in DATA with 0x81 queued behind it.
        tx_data = 8'hFF; valid_a = 1'b1;
        tick();
        tx_data = 8'h81;
        tick();
        valid_a = 1'b0;
        repeat (11) tick();
        total++; if (level_a !== 5'd1)  begin bad++; $display("FAIL rmf_level_pre got=%0d exp=1", level_a); end
        total++; if (busy_a !== 1'b1)   begin bad++; $display("FAIL rmf_busy_pre got=%b exp=1", busy_a); end
        #2 rst = 1'b1;
        #1;
        total++; if (tx_a !== 1'b1)     begin bad++; $display("FAIL rmf_tx got=%b exp=1", tx_a); end
        total++; if (level_a !== 5'd0)  begin bad++; $display("FAIL rmf_level got=%0d exp=0", level_a); end
        total++; if (ready_a !== 1'b0)  begin bad++; $display("FAIL rmf_ready got=%b exp=0", ready_a); end
        total++; if (busy_a !== 1'b0)   begin bad++; $display("FAIL rmf_busy got=%b exp=0", busy_a); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (ready_a !== 1'b1)  begin bad++; $display("FAIL rmf_ready_rel got=%b exp=1", ready_a); end
        repeat (50) tick();
        // 0x00 in START: line low, must return high with no clock edge.
        tx_data = 8'h00; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        tick();
        tick();
        total++; if (tx_a !== 1'b0)     begin bad++; $display("FAIL rms_start got=%b exp=0", tx_a); end
        #2 rst = 1'b1;
        #1;
        total++; if (tx_a !== 1'b1)     begin bad++; $display("FAIL rms_tx got=%b exp=1", tx_a); end
        tick();
        rst = 1'b0;
        repeat (50) tick();
        // Next byte after the abandoned frames goes out intact.
        rx_q.delete();
        dec_en = 1'b1;
        tx_data = 8'h0F; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        guard = 0;
        while (rx_q.size() < 1 && guard < 100) begin tick(); guard++; end
        total++; if (rx_q.size() != 1)  begin bad++; $display("FAIL rmf_count got=%0d exp=1", rx_q.size()); end
        else begin
            total++; if (rx_q[0] !== 9'h10F) begin bad++; $display("FAIL rmf_byte got=%h exp=10f", rx_q[0]); end
        end
        repeat (20) tick();
        dec_en = 1'b0;
    endtask

    task automatic test_random_loopback;
        logic [7:0] rb [24];
        logic       r;
        int         i, guard;
        for (int k = 0; k < 24; k++) rb[k] = 8'($urandom);
        rx_q.delete();
        dec_en = 1'b1;
        i = 0; guard = 0;
        while (i < 24 && guard < 2000) begin
            tx_data = rb[i]; valid_a = 1'b1;
            r = ready_a;
            tick();
            if (r) i++;
            guard++;
        end
        valid_a = 1'b0;
        total++; if (i != 24) begin bad++; $display("FAIL lb_pushed got=%0d exp=24", i); end
        guard = 0;
        while (rx_q.size() < 24 && guard < 1300) begin tick(); guard++; end
        total++; if (rx_q.size() != 24) begin bad++; $display("FAIL lb_count got=%0d exp=24", rx_q.size()); end
        for (int k = 0; k < rx_q.size() && k < 24; k++) begin
            total++; if (rx_q[k] !== {1'b1, rb[k]}) begin bad++; $display("FAIL lb_byte k=%0d got=%h exp=%h", k, rx_q[k], {1'b1, rb[k]}); end
        end
        dec_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        repeat (5) tick();
        test_fifo_full();
        repeat (5) tick();
        test_reset_mid_frame();
        test_random_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
